// File: rtl/spi_dac_pkg.sv
// Shared constants, FSM state type and frame packing for the SPI DAC refresh engine.
package spi_dac_pkg;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] ADDR_ALL         = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP,
        ST_CLR
    } state_e;

    function automatic logic [31:0] pack_frame(input logic [3:0] addr, input logic [15:0] data);
        return {8'h00, CMD_WRITE_UPDATE, addr, data};
    endfunction

endpackage

// File: rtl/spi_dac_rr_arb.sv
// Round-robin first-set search over the dirty flags, starting at the pointer.
module spi_dac_rr_arb #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   sel_o,
    output logic              vld_o
);

    always_comb begin
        logic [CH_W-1:0] idx;
        sel_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(ptr_i) + i) % NUM_CH);
            if (!vld_o && req_i[idx]) begin
                vld_o = 1'b1;
                sel_o = idx;
            end
        end
    end

endmodule

// File: rtl/spi_dac_multi_ch.sv
// Multi-channel SPI DAC refresh engine: shadow registers with dirty tracking,
// round-robin 32-bit write-and-update frames, async-clear pulses and SDO readback.
module spi_dac_multi_ch
    import spi_dac_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4,
    parameter int unsigned CLR_CYC = 8,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   done_ch,
    output logic [31:0]       rb_data,
    output logic [NUM_CH-1:0] dirty,
    output logic              dac_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              dac_clr_n
);

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       rb_shift_q, rb_shift_d;
    logic [31:0]       rb_data_q, rb_data_d;
    logic [NUM_CH-1:0] dirty_q, dirty_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              clr_pend_q, clr_pend_d;
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [CH_W-1:0]   sel;
    logic              sel_vld;
    logic              wr_hit;
    logic [15:0]       sel_data;

    assign wr_hit   = wr_en && (32'(wr_ch) < NUM_CH);
    assign sel_data = 16'(shadow_q[sel]) << (16 - DATA_W);

    spi_dac_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i (dirty_q),
        .ptr_i (ptr_q),
        .sel_o (sel),
        .vld_o (sel_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
        end else if (wr_hit) begin
            shadow_q[wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            dirty_q    <= '0;
            ptr_q      <= '0;
            cur_ch_q   <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rb_shift_q <= rb_shift_d;
            rb_data_q  <= rb_data_d;
            dirty_q    <= dirty_d;
            ptr_q      <= ptr_d;
            cur_ch_q   <= cur_ch_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rb_shift_d = rb_shift_q;
        rb_data_d  = rb_data_q;
        dirty_d    = dirty_q;
        ptr_d      = ptr_q;
        cur_ch_d   = cur_ch_q;
        clr_pend_d = clr_pend_q | clr_req;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_pend_q) begin
                    state_d    = ST_CLR;
                    cnt_d      = '0;
                    clr_pend_d = clr_req;
                end else if (sel_vld) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d      = pack_frame(4'(sel) & ADDR_ALL, sel_data);
                dirty_d[sel] = 1'b0;
                ptr_d        = CH_W'((32'(sel) + 1) % NUM_CH);
                cur_ch_d     = sel;
                cnt_d        = '0;
                bit_d        = '0;
                state_d      = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (cnt_q == CLK_DIV - 1) begin
                    cnt_d      = '0;
                    rb_shift_d = {rb_shift_q[30:0], spi_miso};
                    state_d    = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_q == CLK_DIV - 1) begin
                    cnt_d = '0;
                    if (bit_q == 5'd31) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[30:0], 1'b0};
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            ST_HOLD: begin
                rb_data_d = rb_shift_q;
                cnt_d     = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                // A clear queued during the frame starts straight from GAP so busy never drops in between.
                if (cnt_q == CS_GAP - 1) begin
                    cnt_d = '0;
                    if (clr_pend_q) begin
                        state_d    = ST_CLR;
                        clr_pend_d = clr_req;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            ST_CLR: begin
                if (cnt_q == CLR_CYC - 1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Applied after the LOAD clear so a same-cycle write re-arms the channel.
        if (wr_hit) dirty_d[wr_ch] = 1'b1;
    end

    // Frame bit 31 is always zero, so MOSI idles low through LOAD.
    assign dac_cs_n  = !(state_q inside {ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD});
    assign spi_sck   = (state_q == ST_SHIFT_HI);
    assign spi_mosi  = (state_q inside {ST_SHIFT_LO, ST_SHIFT_HI}) && shift_q[31];
    assign dac_clr_n = (state_q != ST_CLR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_GAP) && (cnt_q == '0);
    assign done_ch   = cur_ch_q;
    assign rb_data   = rb_data_q;
    assign dirty     = dirty_q;

endmodule
